// File: rtl/iob_regfile_sp.sv
// Single-port register file: synchronous write, combinational read, synchronous whole-array clear.
// Optional macro IOB_REGFILE_SP_R0_ZERO_EN hardwires location 0 to zero.
module iob_regfile_sp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] r_data
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef IOB_REGFILE_SP_R0_ZERO_EN
  localparam int FIRST_STORED = 1;
`else
  localparam int FIRST_STORED = 0;
`endif

  logic [DATA_W-1:0] word_w [DEPTH];

  // One register per location so the reset can clear the whole array at once.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      if (gi < FIRST_STORED) begin : g_zero
        assign word_w[gi] = '0;
      end else begin : g_reg
        logic [DATA_W-1:0] word_q;
        logic [DATA_W-1:0] word_d;

        always_comb begin
          word_d = word_q;
          if (we && (addr == ADDR_W'(gi))) begin
            word_d = w_data;
          end
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            word_q <= '0;
          end else begin
            word_q <= word_d;
          end
        end

        assign word_w[gi] = word_q;
      end
    end
  endgenerate

  assign r_data = word_w[addr];

endmodule

// File: tb/tb_iob_regfile_sp.sv
// Bench for iob_regfile_sp: vector table, hand-written corner sequences and a random phase
// against a reference array, with expectations passed through a scoreboard queue.
module tb_iob_regfile_sp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
`ifdef IOB_REGFILE_SP_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] r_data;

  iob_regfile_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .addr  (addr),
    .w_data(w_data),
    .r_data(r_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp;
  } vec_t;

  typedef struct {
    string             name;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp;
  } sb_t;

  localparam int NVEC = 50;
  vec_t vecs[NVEC];
  sb_t  sb[$];
  int   errors = 0;
  int   checks = 0;
  logic [DATA_W-1:0] model[DEPTH];

  function automatic logic [DATA_W-1:0] eff(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    return (R0Z && a == 0) ? '0 : v;
  endfunction

  task automatic expect_push(input string name, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    sb_t s;
    s.name = name;
    s.addr = a;
    s.exp  = e;
    sb.push_back(s);
  endtask

  task automatic check_pop();
    sb_t s;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty got=none exp=entry");
      return;
    end
    s = sb.pop_front();
    checks++;
    if (r_data !== s.exp) begin
      errors++;
      $display("FAIL %s addr=%0d got=%h exp=%h", s.name, s.addr, r_data, s.exp);
    end else begin
      $display("ok   %s addr=%0d r_data=%h", s.name, s.addr, r_data);
    end
  endtask

  task automatic apply(input string name, input logic r, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] e);
    rst    = r;
    we     = w;
    addr   = a;
    w_data = d;
    expect_push(name, a, e);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rw;

    rst = 1'b0; we = 1'b0; addr = '0; w_data = '0;

    vecs[0] = '{rst: 1'b1, we: 1'b0, addr: 4'd0, wdata: 32'h0, exp: 32'h0};
    for (int i = 0; i < DEPTH; i++) begin
      vecs[1 + i]  = '{rst: 1'b0, we: 1'b1, addr: 4'(i), wdata: 32'(i + 32), exp: eff(4'(i), 32'(i + 32))};
      vecs[17 + i] = '{rst: 1'b0, we: 1'b0, addr: 4'(i), wdata: 32'hA5A5_0000 + 32'(i), exp: eff(4'(i), 32'(i + 32))};
      vecs[34 + i] = '{rst: 1'b0, we: 1'b0, addr: 4'(i), wdata: 32'hFFFF_FFFF, exp: 32'h0};
    end
    vecs[33] = '{rst: 1'b1, we: 1'b0, addr: 4'd7, wdata: 32'h0, exp: 32'h0};

    for (int i = 0; i < NVEC; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    end

    // Reset wins over a write on the same edge.
    apply("prio_prewrite", 1'b0, 1'b1, 4'd5, 32'h0000_BEEF, 32'h0000_BEEF);
    apply("prio_rst_we", 1'b1, 1'b1, 4'd5, 32'h0000_DEAD, 32'h0);
    apply("prio_after", 1'b0, 1'b0, 4'd5, 32'h0000_DEAD, 32'h0);

    // Same-address read during write: old value before the edge, new after.
    apply("rdw_setup", 1'b0, 1'b1, 4'd3, 32'd35, 32'd35);
    we = 1'b1; addr = 4'd3; w_data = 32'd99;
    expect_push("rdw_before", 4'd3, 32'd35);
    #1;
    check_pop();
    expect_push("rdw_after", 4'd3, 32'd99);
    @(posedge clk);
    #1;
    check_pop();

    // Combinational read: address change is visible without an edge.
    we = 1'b0; addr = 4'd5;
    expect_push("comb_addr5", 4'd5, 32'h0);
    #1;
    check_pop();
    addr = 4'd3;
    expect_push("comb_addr3", 4'd3, 32'd99);
    #1;
    check_pop();

    // Location 0 behaviour depends on the build option.
    apply("r0_write", 1'b0, 1'b1, 4'd0, 32'h0000_1234, eff(4'd0, 32'h0000_1234));
    apply("r1_write", 1'b0, 1'b1, 4'd1, 32'h0000_0055, 32'h0000_0055);
    apply("r0_read", 1'b0, 1'b0, 4'd0, 32'h0, eff(4'd0, 32'h0000_1234));

    // Random traffic against a reference array, starting from a clear.
    apply("rand_clear", 1'b1, 1'b0, 4'd0, 32'h0, 32'h0);
    for (int k = 0; k < DEPTH; k++) model[k] = '0;
    for (int n = 0; n < 60; n++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 4'($urandom_range(0, DEPTH - 1));
      rd = $urandom;
      if (rw && !(R0Z && ra == 0)) model[ra] = rd;
      apply($sformatf("rand%0d", n), 1'b0, rw, ra, rd, model[ra]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
